// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage: FSM encoding,
// the bubble control constant and default widths.
package pipe_pkg;

    // Default ALU operation code width.
    localparam int ALUOP_W_DEF = 4;

    // Width of the optional hazard-stall counter (STALL_CNT_EN builds).
    localparam int STALL_CNT_W = 16;

    // ID/EX control FSM: RUN evaluates hazards, STALL is the single
    // cycle after a load-use bubble has been inserted.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } id_ex_state_e;

    // Single-bit control group carried from ID to EX.
    typedef struct packed {
        logic reg_w;
        logic mem_r;
        logic mem_w;
        logic alu_src;
    } ctrl_t;

    // A bubble carries no side effects: no write, no memory access.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in the
// ID/EX register and the source registers of the instruction in ID.
module load_use_detect (
    input  logic       is_run,
    input  logic       ex_mem_r,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    always_comb begin
        hazard = is_run && ex_mem_r && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall control and flush handling.
// Optional feature: define STALL_CNT_EN to add the saturating stall_count
// output; without it the counter and the port are absent.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         RsAddr_2,
    input  logic [4:0]         RtAddr_2,
    input  logic [4:0]         RdAddr_2,
    input  logic [DATA_W-1:0]  RsData_2,
    input  logic [DATA_W-1:0]  RtData_2,
    input  logic [DATA_W-1:0]  Imm_2,
    input  logic               Reg_w_2,
    input  logic               Mem_r_2,
    input  logic               Mem_w_2,
    input  logic               ALUsrc_2,
    input  logic [ALUOP_W-1:0] ALUop_2,
    input  logic               flush_3,
    output logic [4:0]         RsAddr_2_to_3,
    output logic [4:0]         RtAddr_2_to_3,
    output logic [4:0]         RdAddr_2_to_3,
    output logic [DATA_W-1:0]  RsData_2_to_3,
    output logic [DATA_W-1:0]  RtData_2_to_3,
    output logic [DATA_W-1:0]  Imm_2_to_3,
    output logic               Reg_w_2_to_3,
    output logic               Mem_r_2_to_3,
    output logic               Mem_w_2_to_3,
    output logic               ALUsrc_2_to_3,
    output logic [ALUOP_W-1:0] ALUop_2_to_3,
    output logic               stall_1_2
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    id_ex_state_e       state_q, state_d;
    logic [4:0]         rs_addr_q, rs_addr_d;
    logic [4:0]         rt_addr_q, rt_addr_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [DATA_W-1:0]  rt_data_q, rt_data_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic               hazard;
    logic               bubble;

    load_use_detect u_load_use_detect (
        .is_run   (state_q == ST_RUN),
        .ex_mem_r (ctrl_q.mem_r),
        .ex_rd    (rd_addr_q),
        .id_rs    (RsAddr_2),
        .id_rt    (RtAddr_2),
        .hazard   (hazard)
    );

    // Next-state and next-contents: a flush or a hazard inserts a bubble,
    // otherwise ID is captured with register-0 writes suppressed.
    always_comb begin
        bubble    = flush_3 || hazard;
        stall_1_2 = hazard && !flush_3 && !rst;
        state_d   = (hazard && !flush_3) ? ST_STALL : ST_RUN;

        rs_addr_d      = RsAddr_2;
        rt_addr_d      = RtAddr_2;
        rd_addr_d      = RdAddr_2;
        rs_data_d      = RsData_2;
        rt_data_d      = RtData_2;
        imm_d          = Imm_2;
        ctrl_d.reg_w   = Reg_w_2 && (RdAddr_2 != 5'd0);
        ctrl_d.mem_r   = Mem_r_2;
        ctrl_d.mem_w   = Mem_w_2;
        ctrl_d.alu_src = ALUsrc_2;
        aluop_d        = ALUop_2;

        if (bubble) begin
            rs_addr_d = '0;
            rt_addr_d = '0;
            rd_addr_d = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            ctrl_d    = CTRL_BUBBLE;
            aluop_d   = '0;
        end
    end

    // Pipeline register and FSM state; reset overrides flush and hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            aluop_q   <= '0;
        end else begin
            state_q   <= state_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            aluop_q   <= aluop_d;
        end
    end

    assign RsAddr_2_to_3 = rs_addr_q;
    assign RtAddr_2_to_3 = rt_addr_q;
    assign RdAddr_2_to_3 = rd_addr_q;
    assign RsData_2_to_3 = rs_data_q;
    assign RtData_2_to_3 = rt_data_q;
    assign Imm_2_to_3    = imm_q;
    assign Reg_w_2_to_3  = ctrl_q.reg_w;
    assign Mem_r_2_to_3  = ctrl_q.mem_r;
    assign Mem_w_2_to_3  = ctrl_q.mem_w;
    assign ALUsrc_2_to_3 = ctrl_q.alu_src;
    assign ALUop_2_to_3  = aluop_q;

`ifdef STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count each RUN->STALL entry, holding at all-ones once saturated.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_1_2 && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a vector table of instructions with
// expected stall and bubble/capture outcome, plus a counter saturation run
// when STALL_CNT_EN is defined.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct packed {
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] imm;
        logic          regw;
        logic          memr;
        logic          memw;
        logic          alusrc;
        logic [AW-1:0] aluop;
    } ins_t;

    typedef struct {
        string name;
        ins_t  ins;
        logic  flush;
        logic  rst;
        logic  exp_stall;
        logic  exp_bubble;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [4:0]    RsAddr_2, RtAddr_2, RdAddr_2;
    logic [DW-1:0] RsData_2, RtData_2, Imm_2;
    logic          Reg_w_2, Mem_r_2, Mem_w_2, ALUsrc_2;
    logic [AW-1:0] ALUop_2;
    logic          flush_3;
    logic [4:0]    RsAddr_2_to_3, RtAddr_2_to_3, RdAddr_2_to_3;
    logic [DW-1:0] RsData_2_to_3, RtData_2_to_3, Imm_2_to_3;
    logic          Reg_w_2_to_3, Mem_r_2_to_3, Mem_w_2_to_3, ALUsrc_2_to_3;
    logic [AW-1:0] ALUop_2_to_3;
    logic          stall_1_2;
`ifdef STALL_CNT_EN
    logic [15:0]   stall_count;
`endif

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    ins_t exp_q[$];
    vec_t vecs[$];

    id_ex_stage #(.DATA_W(DW), .ALUOP_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .RsAddr_2      (RsAddr_2),
        .RtAddr_2      (RtAddr_2),
        .RdAddr_2      (RdAddr_2),
        .RsData_2      (RsData_2),
        .RtData_2      (RtData_2),
        .Imm_2         (Imm_2),
        .Reg_w_2       (Reg_w_2),
        .Mem_r_2       (Mem_r_2),
        .Mem_w_2       (Mem_w_2),
        .ALUsrc_2      (ALUsrc_2),
        .ALUop_2       (ALUop_2),
        .flush_3       (flush_3),
        .RsAddr_2_to_3 (RsAddr_2_to_3),
        .RtAddr_2_to_3 (RtAddr_2_to_3),
        .RdAddr_2_to_3 (RdAddr_2_to_3),
        .RsData_2_to_3 (RsData_2_to_3),
        .RtData_2_to_3 (RtData_2_to_3),
        .Imm_2_to_3    (Imm_2_to_3),
        .Reg_w_2_to_3  (Reg_w_2_to_3),
        .Mem_r_2_to_3  (Mem_r_2_to_3),
        .Mem_w_2_to_3  (Mem_w_2_to_3),
        .ALUsrc_2_to_3 (ALUsrc_2_to_3),
        .ALUop_2_to_3  (ALUop_2_to_3),
        .stall_1_2     (stall_1_2)
`ifdef STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic memr,
                                input logic memw, input logic regw,
                                input logic alusrc, input logic [AW-1:0] aluop);
        ins_t i;
        i.rs     = rs;
        i.rt     = rt;
        i.rd     = rd;
        i.rsd    = $urandom;
        i.rtd    = $urandom;
        i.imm    = $urandom;
        i.regw   = regw;
        i.memr   = memr;
        i.memw   = memw;
        i.alusrc = alusrc;
        i.aluop  = aluop;
        return i;
    endfunction

    function automatic vec_t mv(input string name, input ins_t ins, input logic flush,
                                input logic r, input logic es, input logic eb);
        vec_t v;
        v.name       = name;
        v.ins        = ins;
        v.flush      = flush;
        v.rst        = r;
        v.exp_stall  = es;
        v.exp_bubble = eb;
        return v;
    endfunction

    function automatic ins_t dut_out();
        ins_t o;
        o.rs     = RsAddr_2_to_3;
        o.rt     = RtAddr_2_to_3;
        o.rd     = RdAddr_2_to_3;
        o.rsd    = RsData_2_to_3;
        o.rtd    = RtData_2_to_3;
        o.imm    = Imm_2_to_3;
        o.regw   = Reg_w_2_to_3;
        o.memr   = Mem_r_2_to_3;
        o.memw   = Mem_w_2_to_3;
        o.alusrc = ALUsrc_2_to_3;
        o.aluop  = ALUop_2_to_3;
        return o;
    endfunction

    // Drive one cycle: check the combinational stall, queue the expected
    // ID/EX contents, then compare them after the clock edge.
    task automatic run_vec(input vec_t v, input int idx, input bit quiet);
        ins_t exp;
        ins_t got;
        @(negedge clk);
        RsAddr_2 = v.ins.rs;   RtAddr_2 = v.ins.rt;   RdAddr_2 = v.ins.rd;
        RsData_2 = v.ins.rsd;  RtData_2 = v.ins.rtd;  Imm_2    = v.ins.imm;
        Reg_w_2  = v.ins.regw; Mem_r_2  = v.ins.memr; Mem_w_2  = v.ins.memw;
        ALUsrc_2 = v.ins.alusrc; ALUop_2 = v.ins.aluop;
        flush_3  = v.flush;    rst      = v.rst;
        #1;
        checks++;
        if (stall_1_2 !== v.exp_stall) begin
            errors++;
            $display("FAIL %s[%0d] stall: got %b expected %b", v.name, idx, stall_1_2, v.exp_stall);
        end
        if (v.exp_bubble || v.rst) begin
            exp = '0;
        end else begin
            exp = v.ins;
            exp.regw = v.ins.regw && (v.ins.rd != 5'd0);
        end
        exp_q.push_back(exp);
        if (v.rst) exp_cnt = 0;
        else if (v.exp_stall && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] idex: got %h expected %h", v.name, idx, got, exp);
        end
`ifdef STALL_CNT_EN
        checks++;
        if (stall_count !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL %s[%0d] stall_count: got %0d expected %0d", v.name, idx, stall_count, exp_cnt);
        end
`endif
        if (!quiet)
            $display("vec %0d %s: stall=%b out rs=%0d rt=%0d rd=%0d regw=%b memr=%b",
                     idx, v.name, v.exp_stall, got.rs, got.rt, got.rd, got.regw, got.memr);
    endtask

    initial begin
        ins_t lw8, add9, lw0, rd0, lw5, sub7, lw6, and10, or11, addi0, lw12, sw12, add13, lwdep;
        lw8   = mk(5'd1,  5'd0,  5'd8,  1, 0, 1, 1, 4'd0);
        add9  = mk(5'd8,  5'd10, 5'd9,  0, 0, 1, 0, 4'd2);
        lw0   = mk(5'd2,  5'd0,  5'd0,  1, 0, 1, 1, 4'd0);
        rd0   = mk(5'd0,  5'd0,  5'd3,  0, 0, 1, 0, 4'd2);
        lw5   = mk(5'd4,  5'd0,  5'd5,  1, 0, 1, 1, 4'd0);
        sub7  = mk(5'd6,  5'd5,  5'd7,  0, 0, 1, 0, 4'd6);
        lw6   = mk(5'd1,  5'd0,  5'd6,  1, 0, 1, 1, 4'd0);
        and10 = mk(5'd6,  5'd2,  5'd10, 0, 0, 1, 0, 4'd4);
        or11  = mk(5'd7,  5'd6,  5'd11, 0, 0, 1, 0, 4'd5);
        addi0 = mk(5'd3,  5'd0,  5'd0,  0, 0, 1, 1, 4'd2);
        lw12  = mk(5'd2,  5'd0,  5'd12, 1, 0, 1, 1, 4'd0);
        sw12  = mk(5'd3,  5'd12, 5'd0,  0, 1, 0, 1, 4'd2);
        add13 = mk(5'd12, 5'd12, 5'd13, 0, 0, 1, 0, 4'd2);
        lwdep = mk(5'd8,  5'd0,  5'd8,  1, 0, 1, 1, 4'd0);

        //              name          ins    flush rst stall bubble
        vecs.push_back(mv("reset",      lw8,   0, 1, 0, 1));
        vecs.push_back(mv("lw8",        lw8,   0, 0, 0, 0));
        vecs.push_back(mv("add_hazard", add9,  0, 0, 1, 1));
        vecs.push_back(mv("add_resume", add9,  0, 0, 0, 0));
        vecs.push_back(mv("lw_r0",      lw0,   0, 0, 0, 0));
        vecs.push_back(mv("use_r0",     rd0,   0, 0, 0, 0));
        vecs.push_back(mv("lw5",        lw5,   0, 0, 0, 0));
        vecs.push_back(mv("haz_flush",  sub7,  1, 0, 0, 1));
        vecs.push_back(mv("lw6",        lw6,   0, 0, 0, 0));
        vecs.push_back(mv("and_hazard", and10, 0, 0, 1, 1));
        vecs.push_back(mv("stall_flush",and10, 1, 0, 0, 1));
        vecs.push_back(mv("and_again",  and10, 0, 0, 0, 0));
        vecs.push_back(mv("lw6_b",      lw6,   0, 0, 0, 0));
        vecs.push_back(mv("or_hazard",  or11,  0, 0, 1, 1));
        vecs.push_back(mv("rst_stall",  or11,  0, 1, 0, 1));
        vecs.push_back(mv("wr_r0",      addi0, 0, 0, 0, 0));
        vecs.push_back(mv("lw12",       lw12,  0, 0, 0, 0));
        vecs.push_back(mv("sw_hazard",  sw12,  0, 0, 1, 1));
        vecs.push_back(mv("sw_resume",  sw12,  0, 0, 0, 0));
        vecs.push_back(mv("add13",      add13, 0, 0, 0, 0));

        rst = 1'b1; flush_3 = 1'b0;
        RsAddr_2 = '0; RtAddr_2 = '0; RdAddr_2 = '0;
        RsData_2 = '0; RtData_2 = '0; Imm_2 = '0;
        Reg_w_2 = 1'b0; Mem_r_2 = 1'b0; Mem_w_2 = 1'b0; ALUsrc_2 = 1'b0; ALUop_2 = '0;

        foreach (vecs[i]) run_vec(vecs[i], i, 1'b0);

        // Back-to-back dependent loads: one stall every other cycle.
        run_vec(mv("cnt_reset", lwdep, 0, 1, 0, 1), 0, 1'b0);
`ifdef STALL_CNT_EN
        for (int k = 0; k < 131080; k++)
            run_vec(mv("sat", lwdep, 0, 0, k[0], k[0]), k, 1'b1);
        $display("saturation run: stall_count=%0d expected %0d", stall_count, exp_cnt);
        run_vec(mv("sat_rst", lwdep, 0, 1, 0, 1), 0, 1'b0);
`else
        for (int k = 0; k < 8; k++)
            run_vec(mv("chain", lwdep, 0, 0, k[0], k[0]), k, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
